// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between the core and the debug/loader port.
// Optional ARB_RR_EN selects round-robin tie-break in IDLE; otherwise debug wins ties.
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_gnt,
    output logic          core_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_gnt,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd,
    output logic [1:0]    owner
);

    localparam int unsigned HCW = $clog2(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CORE = 2'b01,
        DBG  = 2'b10
    } owner_t;

    owner_t         state;
    owner_t         nxt;
    logic [HCW-1:0] hold_cnt;
    logic           other_req;
    logic           tie_dbg;

`ifdef ARB_RR_EN
    // Remembers which requester was granted last; resets to core so debug wins the first tie.
    logic last_dbg;
    assign tie_dbg = ~last_dbg;
`else
    assign tie_dbg = 1'b1;
`endif

    // Next owner from the current owner, both requests and the hold counter.
    always_comb begin
        nxt       = state;
        other_req = 1'b0;
        case (state)
            IDLE: begin
                if (core_req && dbg_req) begin
                    nxt = tie_dbg ? DBG : CORE;
                end else if (core_req) begin
                    nxt = CORE;
                end else if (dbg_req) begin
                    nxt = DBG;
                end
            end
            CORE: begin
                other_req = dbg_req;
                if (!core_req) begin
                    nxt = dbg_req ? DBG : IDLE;
                end else if (dbg_req && (hold_cnt == HOLD_MAX)) begin
                    nxt = DBG;
                end
            end
            DBG: begin
                other_req = core_req;
                if (!dbg_req) begin
                    nxt = core_req ? CORE : IDLE;
                end else if (core_req && (hold_cnt == HOLD_MAX) && !dbg_lock) begin
                    nxt = CORE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
`ifdef ARB_RR_EN
            last_dbg <= 1'b0;
`endif
        end else begin
            state <= nxt;
            // Hold counter only runs while the current owner keeps the other side waiting.
            if ((nxt != state) || !other_req) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HCW'(1);
            end
`ifdef ARB_RR_EN
            if (nxt != IDLE) begin
                last_dbg <= (nxt == DBG);
            end
`endif
        end
    end

    // Port muxing and grants derive from the registered owner and the live requests.
    always_comb begin
        core_gnt   = (state == CORE) && core_req;
        dbg_gnt    = (state == DBG) && dbg_req;
        core_stall = core_req && !core_gnt;
        mem_a      = '0;
        mem_wd     = '0;
        case (state)
            CORE: begin
                mem_a  = core_addr;
                mem_wd = core_wdata;
            end
            DBG: begin
                mem_a  = dbg_addr;
                mem_wd = dbg_wdata;
            end
            default: ;
        endcase
        mem_we = !rst && ((core_gnt && core_we) || (dbg_gnt && dbg_we));
    end

    assign owner      = state;
    assign core_rdata = mem_rd;
    assign dbg_rdata  = mem_rd;

endmodule
